// File: rtl/ctrl_exibicao_pkg.sv
// Shared types and default sizing for the ALU-result display controller.
package pkg_exibicao;

  typedef enum logic {
    CAPTURA = 1'b0,
    EXIBE   = 1'b1
  } estado_t;

  localparam int unsigned PROFUNDIDADE_PADRAO = 25;
  localparam int unsigned AW_PADRAO           = 5;

endpackage

// File: rtl/ctrl_exibicao_if.sv
// Bundle of CPU/button inputs and display-memory outputs of ctrl_exibicao.
interface ctrl_exibicao_if
  import pkg_exibicao::*;
#(
  parameter int unsigned AW = AW_PADRAO
);

  logic          instr_valida;
  logic          cpu_halt;
  logic          proximo;
  logic          repetir;
  logic          mem_we;
  logic [AW-1:0] mem_waddr;
  logic [AW-1:0] mem_raddr;
  logic [AW:0]   num_entradas;
  logic          cheio;
  logic          modo_exibe;
  logic          exib_valida;
  logic          fim_lista;

  modport master (
    input  instr_valida, cpu_halt, proximo, repetir,
    output mem_we, mem_waddr, mem_raddr, num_entradas,
           cheio, modo_exibe, exib_valida, fim_lista
  );

  modport slave (
    output instr_valida, cpu_halt, proximo, repetir,
    input  mem_we, mem_waddr, mem_raddr, num_entradas,
           cheio, modo_exibe, exib_valida, fim_lista
  );

endinterface

// File: rtl/ctrl_exibicao_debounce_botao.sv
// Push-button conditioner: 2-FF synchroniser, stability counter, one-cycle pulse on accepted rising edge.
module debounce_botao #(
  parameter int unsigned DEBOUNCE_CICLOS = 1000000
) (
  input  logic Clk,
  input  logic Reset,
  input  logic proximo,
  output logic adv
);

  localparam int unsigned   CW      = (DEBOUNCE_CICLOS > 1) ? $clog2(DEBOUNCE_CICLOS) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CICLOS - 1);

  logic          s1_q, s2_q;
  logic          nivel_q, nivel_d;
  logic          ant_q;
  logic [CW-1:0] cnt_q, cnt_d;

  // Counter runs only while the synced level disagrees with the accepted one,
  // so any bounce back to the accepted level restarts it.
  always_comb begin
    nivel_d = nivel_q;
    cnt_d   = '0;
    if (s2_q != nivel_q) begin
      if (cnt_q == CNT_MAX) nivel_d = s2_q;
      else                  cnt_d   = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      nivel_q <= 1'b0;
      ant_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      s1_q    <= proximo;
      s2_q    <= s1_q;
      nivel_q <= nivel_d;
      ant_q   <= nivel_q;
      cnt_q   <= cnt_d;
    end
  end

  assign adv = nivel_q && !ant_q;

endmodule

// File: rtl/ctrl_exibicao.sv
// Display-memory controller: captures committed ALU results, then steps readout on debounced button.
// Optional feature macro: AUTO_AVANCO_EN (idle auto-advance timer in EXIBE).
module ctrl_exibicao
  import pkg_exibicao::*;
#(
  parameter int unsigned PROFUNDIDADE    = PROFUNDIDADE_PADRAO,
  parameter int unsigned AW              = AW_PADRAO,
  parameter int unsigned DEBOUNCE_CICLOS = 1000000,
  parameter int unsigned AUTO_CICLOS     = 50000000
) (
  input logic            Clk,
  input logic            Reset,
  ctrl_exibicao_if.master bus
);

  localparam logic [AW:0]   PROF_C = (AW+1)'(PROFUNDIDADE);
  localparam logic [AW-1:0] ULTIMO = AW'(PROFUNDIDADE - 1);

  estado_t       state_q, state_d;
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [AW:0]   count_q, count_d;
  logic          fim_q, fim_d;
  logic          cheio;
  logic          we;
  logic          adv_btn;
  logic          adv;

  debounce_botao #(
    .DEBOUNCE_CICLOS(DEBOUNCE_CICLOS)
  ) u_debounce (
    .Clk    (Clk),
    .Reset  (Reset),
    .proximo(bus.proximo),
    .adv    (adv_btn)
  );

`ifdef AUTO_AVANCO_EN
  localparam int unsigned   TW      = (AUTO_CICLOS > 1) ? $clog2(AUTO_CICLOS) : 1;
  localparam logic [TW-1:0] TMR_MAX = TW'(AUTO_CICLOS - 1);

  logic [TW-1:0] tmr_q, tmr_d;
  logic          adv_auto;

  // Coincident manual and timer pulses merge into one adv; timer freezes at end of list.
  always_comb begin
    tmr_d    = tmr_q;
    adv_auto = 1'b0;
    if (state_q != EXIBE || count_q == '0) begin
      tmr_d = '0;
    end else if (!fim_q) begin
      if (tmr_q == TMR_MAX) begin
        adv_auto = 1'b1;
        tmr_d    = '0;
      end else if (adv_btn) begin
        tmr_d = '0;
      end else begin
        tmr_d = tmr_q + 1'b1;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) tmr_q <= '0;
    else       tmr_q <= tmr_d;
  end

  assign adv = adv_btn || adv_auto;
`else
  assign adv = adv_btn;
`endif

  assign cheio = (count_q == PROF_C);

  always_comb begin
    state_d = state_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    fim_d   = fim_q;
    we      = 1'b0;
    case (state_q)
      CAPTURA: begin
        we = bus.instr_valida && !cheio;
        if (we) begin
          wptr_d  = (wptr_q == ULTIMO) ? wptr_q : wptr_q + 1'b1;
          count_d = count_q + 1'b1;
        end
        if (bus.cpu_halt || (we && count_q == PROF_C - 1'b1)) begin
          state_d = EXIBE;
          rptr_d  = '0;
          fim_d   = 1'b0;
        end
      end
      EXIBE: begin
        if (adv && count_q != '0) begin
          if ({1'b0, rptr_q} < count_q - 1'b1) begin
            rptr_d = rptr_q + 1'b1;
          end else if (bus.repetir) begin
            rptr_d = '0;
            fim_d  = 1'b0;
          end else begin
            fim_d = 1'b1;
          end
        end
      end
      default: state_d = CAPTURA;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= CAPTURA;
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      fim_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      fim_q   <= fim_d;
    end
  end

  assign bus.mem_we       = we && !Reset;
  assign bus.mem_waddr    = wptr_q;
  assign bus.mem_raddr    = rptr_q;
  assign bus.num_entradas = count_q;
  assign bus.cheio        = cheio;
  assign bus.modo_exibe   = (state_q == EXIBE);
  assign bus.exib_valida  = (state_q == EXIBE) && (count_q != '0);
  assign bus.fim_lista    = fim_q;

endmodule
